// File: rtl/shift_in.sv
// Serial byte receiver for the shiftOut link.
// Frame: start '1', data[0]..data[7] LSB first, stop '0'; each bit CYCLES_PER_BIT clocks.
// The recovered byte is held until the microprocessor acknowledges it; framing
// errors are reported per frame and overruns are sticky until reset.
//
// state | meaning
// IDLE  | waiting for a 0->1 edge on the synchronized line
// START | counting to the middle of the start bit to confirm it
// DATA  | sampling the eight data bits at mid-bit, LSB first
// STOP  | sampling the stop bit and delivering the byte
module shift_in #(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       rdAck,
  output logic [7:0] byteOut,
  output logic       valid,
  output logic       frameErr,
  output logic       overrun
);

  localparam int HALF = CYCLES_PER_BIT / 2;
  localparam int CW   = $clog2(CYCLES_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           sync_q1;
  logic           ins;
  logic           ins_d;
  logic [CW-1:0]  cnt;
  logic [3:0]     bit_idx;
  logic [7:0]     shreg;

  logic           tick;
  logic           rise;
  logic           load_half;
  logic           shift_en;
  logic           clr_idx;
  logic           deliver;

  assign tick = (cnt == '0);
  assign rise = ins && !ins_d;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      ins     <= 1'b0;
      ins_d   <= 1'b0;
    end else begin
      sync_q1 <= in;
      ins     <= sync_q1;
      ins_d   <= ins;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; every non-idle decision happens on the mid-bit tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rise) state_nxt = START;
      START: if (tick) state_nxt = ins ? DATA : IDLE;
      DATA:  if (tick && bit_idx == 4'd7) state_nxt = STOP;
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    load_half = 1'b0;
    shift_en  = 1'b0;
    clr_idx   = 1'b0;
    deliver   = 1'b0;
    case (state)
      IDLE:  load_half = rise;
      START: clr_idx   = tick;
      DATA:  shift_en  = tick;
      STOP:  deliver   = tick;
      default: ;
    endcase
  end

  // Bit-cycle down-counter: half a bit to reach mid start bit, then whole bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load_half) begin
      cnt <= CW'(HALF - 1);
    end else if (state != IDLE) begin
      if (tick) cnt <= CW'(CYCLES_PER_BIT - 1);
      else      cnt <= cnt - CW'(1);
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_idx <= 4'd0;
      shreg   <= 8'd0;
    end else if (clr_idx) begin
      bit_idx <= 4'd0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + 4'd1;
      shreg   <= {ins, shreg[7:1]};
    end
  end

  // Output holding registers; a new byte takes priority over an ack in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byteOut  <= 8'd0;
      valid    <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else if (deliver) begin
      byteOut  <= shreg;
      valid    <= 1'b1;
      frameErr <= ins;
      if (valid && !rdAck) overrun <= 1'b1;
    end else if (valid && rdAck) begin
      valid <= 1'b0;
    end
  end

endmodule
